// File: rtl/tx_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tx_link_scheduler
// Purpose  : Shares one 8b10b serial transmitter among NUM_REQ byte-stream
//            requesters. Generates the transmitter bit-rate enable, arbitrates
//            round-robin in bursts (header byte + up to MAX_BURST payload
//            bytes) and writes the transmitter FIFO while honouring its full
//            flag.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            run                 - allow new grants
//            reqValid/Data/Last  - per-requester byte stream (byte i at
//                                  reqData[8i+7:8i])
//            reqReady            - byte accepted when reqValid also high
//            txFull              - transmitter FIFO full
//            txData/WriteStrobe  - registered one-cycle FIFO write
//            txEn                - one-cycle pulse every PERIOD clocks
//            grant, busy         - one-hot current owner, not-idle flag
// Revision : 1.0 - initial release
// ============================================================================
module tx_link_scheduler #(
  parameter int PERIOD    = 10,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqLast,
  output logic [NUM_REQ-1:0]   reqReady,
  input  logic                 txFull,
  output logic [7:0]           txData,
  output logic                 txWriteStrobe,
  output logic                 txEn,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);

  localparam int         IDXW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] BIT_LAST  = 16'(PERIOD - 1);
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [15:0]        bit_cnt_q, bit_cnt_d;
  logic               tx_en_q, tx_en_d;
  logic               strobe_q, strobe_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic               gap_q, gap_d;

  // Unpack the flat data bus so the owner's byte is a simple array lookup.
  logic [7:0] req_byte [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = reqData[8*g +: 8];
  end

  logic       own_valid, own_last, slot;
  logic [7:0] own_byte;
  logic [5:0] hdr_idx;

  assign own_valid = reqValid[owner_q];
  assign own_last  = reqLast[owner_q];
  assign own_byte  = req_byte[owner_q];
  // A write slot needs a non-full FIFO and one settle cycle after the last
  // write, so txFull is always resampled after the FIFO has updated.
  assign slot      = !txFull && !gap_q;

  always_comb begin
    hdr_idx             = '0;
    hdr_idx[IDXW-1:0]   = owner_q;
  end

  // Round-robin pick: the lowest valid index above the pointer wins, else
  // the lowest valid index at or below it (wrap-around, pointer included).
  logic            hi_found, lo_found, sel_found;
  logic [IDXW-1:0] hi_idx, lo_idx, sel_idx;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqValid[i]) begin
        if (i > int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDXW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IDXW'(i);
        end
      end
    end
    sel_found = hi_found | lo_found;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    reqReady = '0;
    if (state_q == S_DATA && slot) begin
      reqReady = grant_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = (bit_cnt_q == BIT_LAST) ? 16'd0 : bit_cnt_q + 16'd1;
    tx_en_d     = (bit_cnt_q == BIT_LAST);
    strobe_d    = 1'b0;
    data_d      = data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gap_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        burst_cnt_d = 8'd0;
        if (run && sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          owner_d          = sel_idx;
          ptr_d            = sel_idx;
          state_d          = S_HEADER;
        end
      end
      S_HEADER: begin
        // The header goes out regardless of the owner's current valid.
        if (slot) begin
          strobe_d = 1'b1;
          data_d   = {2'b11, hdr_idx};
          gap_d    = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (own_valid && slot) begin
          strobe_d    = 1'b1;
          data_d      = own_byte;
          gap_d       = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (own_last || (burst_cnt_q + 8'd1 == BURST_MAX)) begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 16'd0;
      tx_en_q     <= 1'b0;
      strobe_q    <= 1'b0;
      data_q      <= 8'd0;
      grant_q     <= '0;
      ptr_q       <= IDXW'(NUM_REQ - 1);
      owner_q     <= '0;
      burst_cnt_q <= 8'd0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_en_q     <= tx_en_d;
      strobe_q    <= strobe_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign txData        = data_q;
  assign txWriteStrobe = strobe_q;
  assign txEn          = tx_en_q;
  assign grant         = grant_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire
